// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush, forwarding selects and syscall drain sequencing
// for a 5-stage MIPS pipeline, tracking in-flight GRF writers in E/M/W.
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int SRC_W = 4,
  parameter logic [SRC_W-1:0] SRC_DISABLE = '0,
  parameter logic [SRC_W-1:0] SRC_MEM = SRC_W'(2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             dValid,
  input  logic [REG_W-1:0] dRead1,
  input  logic [REG_W-1:0] dRead2,
  input  logic [REG_W-1:0] dDest,
  input  logic [SRC_W-1:0] dWriteSrc,
  input  logic             dNeedJump,
  input  logic             dBye,
  output logic             stallFD,
  output logic             flushE,
  output logic [1:0]       fwdD1,
  output logic [1:0]       fwdD2,
  output logic [1:0]       fwdE1,
  output logic [1:0]       fwdE2,
  output logic             draining,
  output logic             halted
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
  logic [1:0] r_state, w_next;
  logic r_e_valid, r_m_valid, r_w_valid;
  logic [REG_W-1:0] r_e_dest, r_e_read1, r_e_read2, r_m_dest, r_w_dest;
  logic [SRC_W-1:0] r_e_src, r_m_src, r_w_src;
  logic w_e1, w_e2, w_m1, w_m2, w_w1, w_w2, w_me1, w_me2, w_we1, w_we2;
  logic w_hazard, w_issue, w_run, w_empty;
  function automatic logic writes(input logic v, input logic [REG_W-1:0] dest,
                                  input logic [SRC_W-1:0] src, input logic [REG_W-1:0] r);
    return v && src != SRC_DISABLE && dest == r && r != '0;
  endfunction
  assign w_e1  = writes(r_e_valid, r_e_dest, r_e_src, dRead1);
  assign w_e2  = writes(r_e_valid, r_e_dest, r_e_src, dRead2);
  assign w_m1  = writes(r_m_valid, r_m_dest, r_m_src, dRead1);
  assign w_m2  = writes(r_m_valid, r_m_dest, r_m_src, dRead2);
  assign w_w1  = writes(r_w_valid, r_w_dest, r_w_src, dRead1);
  assign w_w2  = writes(r_w_valid, r_w_dest, r_w_src, dRead2);
  assign w_me1 = writes(r_m_valid, r_m_dest, r_m_src, r_e_read1);
  assign w_me2 = writes(r_m_valid, r_m_dest, r_m_src, r_e_read2);
  assign w_we1 = writes(r_w_valid, r_w_dest, r_w_src, r_e_read1);
  assign w_we2 = writes(r_w_valid, r_w_dest, r_w_src, r_e_read2);
  // loads cannot forward from E; jumps compare in D so any E writer, or a load in M, stalls
  assign w_hazard = dValid && (
    ((w_e1 || w_e2) && (r_e_src == SRC_MEM || dNeedJump)) ||
    ((w_m1 || w_m2) && dNeedJump && r_m_src == SRC_MEM));
  assign w_run    = r_state == RUN;
  assign w_issue  = dValid && !dBye && !w_hazard && w_run;
  assign w_empty  = !r_e_valid && !r_m_valid && !r_w_valid;
  assign stallFD  = freeze || w_hazard || !w_run;
  assign flushE   = w_hazard || !w_run;
  assign draining = r_state == DRAIN;
  assign halted   = r_state == HALTED;
  assign fwdD1 = w_m1 && r_m_src != SRC_MEM ? 2'd1 : w_w1 ? 2'd2 : 2'd0;
  assign fwdD2 = w_m2 && r_m_src != SRC_MEM ? 2'd1 : w_w2 ? 2'd2 : 2'd0;
  assign fwdE1 = w_me1 && r_m_src != SRC_MEM ? 2'd1 : w_we1 ? 2'd2 : 2'd0;
  assign fwdE2 = w_me2 && r_m_src != SRC_MEM ? 2'd1 : w_we2 ? 2'd2 : 2'd0;
  assign w_next = w_run ? (dValid && dBye && !w_hazard ? DRAIN : RUN) :
                  r_state == DRAIN ? (w_empty ? HALTED : DRAIN) : HALTED;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_e_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_w_valid <= 1'b0;
      r_e_dest  <= '0;
      r_e_src   <= '0;
      r_e_read1 <= '0;
      r_e_read2 <= '0;
    end else if (!freeze) begin
      r_state   <= w_next;
      r_w_valid <= r_m_valid;
      r_w_dest  <= r_m_dest;
      r_w_src   <= r_m_src;
      r_m_valid <= r_e_valid;
      r_m_dest  <= r_e_dest;
      r_m_src   <= r_e_src;
      r_e_valid <= w_issue;
      r_e_dest  <= w_issue ? dDest : '0;
      r_e_src   <= w_issue ? dWriteSrc : '0;
      r_e_read1 <= w_issue ? dRead1 : '0;
      r_e_read2 <= w_issue ? dRead2 : '0;
    end
  end
endmodule
